// File: rtl/lc3_mem_access_pkg.sv
// Shared encodings for the LC3 memory-access stage: access modes, controller
// states and the default wait-cycle limit.
package lc3_mem_access_pkg;

    typedef enum logic [1:0] {
        MODE_LD  = 2'b00,
        MODE_ST  = 2'b01,
        MODE_LDI = 2'b10,
        MODE_STI = 2'b11
    } mem_mode_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRD  = 3'd1,
        S_PCAP = 3'd2,
        S_RD   = 3'd3,
        S_CAP  = 3'd4,
        S_WR   = 3'd5,
        S_DONE = 3'd6
    } mem_state_e;

    localparam int TIMEOUT_DEFAULT = 16;

    // Indirect modes fetch the pointer first; direct modes go straight to the access.
    function automatic mem_state_e first_state(input mem_mode_e m);
        mem_state_e s;
        case (m)
            MODE_LD:  s = S_RD;
            MODE_ST:  s = S_WR;
            default:  s = S_PRD;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lc3_mem_timeout.sv
// Wait-cycle counter for the memory-access stage; expired marks the last
// permitted wait cycle.
module lc3_mem_timeout #(
    parameter int LIMIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] count;

    // Saturates at LIMIT-1 so an ignored expiry never wraps back to zero.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/lc3_mem_access.sv
// LC3 memory-access stage controller (LD/ST/LDI/STI against synchronous data memory).
// Optional wait timeout enabled by defining MEM_ACCESS_TIMEOUT_EN.
module lc3_mem_access
    import lc3_mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [15:0] M_addr,
    input  logic [15:0] M_data,
    input  logic [15:0] Data_dout,
    input  logic        complete_data,
    output logic [15:0] Data_addr,
    output logic [15:0] Data_din,
    output logic        Data_rd,
    output logic [15:0] memout,
    output logic        busy,
    output logic        done,
    output logic        err
);

    mem_state_e  state, state_next;
    mem_mode_e   mode_q, mode_next;
    logic [15:0] data_q, data_next;
    logic [15:0] addr_next, din_next, memout_next;
    logic        rd_next, busy_next, done_next, err_next;
    logic        timeout_hit;

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic wait_state;
    logic tmo_clear;
    logic tmo_expired;

    // The counter restarts on every state change so each wait state gets a full budget.
    assign wait_state = (state == S_PCAP) || (state == S_CAP) || (state == S_WR);
    assign tmo_clear  = (state_next != state);

    lc3_mem_timeout #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (tmo_clear),
        .enable  (wait_state),
        .expired (tmo_expired)
    );

    assign timeout_hit = tmo_expired && !complete_data;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        mode_next   = mode_q;
        data_next   = data_q;
        addr_next   = Data_addr;
        din_next    = Data_din;
        memout_next = memout;
        busy_next   = busy;
        err_next    = err;

        case (state)
            S_IDLE: begin
                if (start) begin
                    mode_next  = mem_mode_e'(mode);
                    data_next  = M_data;
                    addr_next  = M_addr;
                    busy_next  = 1'b1;
                    err_next   = 1'b0;
                    state_next = first_state(mem_mode_e'(mode));
                end
            end
            S_PRD: begin
                state_next = S_PCAP;
            end
            S_PCAP: begin
                if (complete_data) begin
                    addr_next  = Data_dout;
                    state_next = (mode_q == MODE_LDI) ? S_RD : S_WR;
                end else if (timeout_hit) begin
                    err_next   = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_RD: begin
                state_next = S_CAP;
            end
            S_CAP: begin
                if (complete_data) begin
                    memout_next = Data_dout;
                    state_next  = S_DONE;
                end else if (timeout_hit) begin
                    err_next   = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_WR: begin
                if (complete_data) begin
                    state_next = S_DONE;
                end else if (timeout_hit) begin
                    err_next   = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        if (state_next == S_WR) begin
            din_next = data_next;
        end
        rd_next   = (state_next != S_WR);
        done_next = (state_next == S_DONE);
        if (state_next == S_DONE) begin
            busy_next = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= S_IDLE;
            mode_q    <= MODE_LD;
            data_q    <= '0;
            Data_addr <= '0;
            Data_din  <= '0;
            Data_rd   <= 1'b1;
            memout    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            mode_q    <= mode_next;
            data_q    <= data_next;
            Data_addr <= addr_next;
            Data_din  <= din_next;
            Data_rd   <= rd_next;
            memout    <= memout_next;
            busy      <= busy_next;
            done      <= done_next;
            err       <= err_next;
        end
    end

endmodule

// File: tb/tb_lc3_mem_access.sv
// Directed self-checking bench for lc3_mem_access with a synchronous memory model.
// The timeout case runs only when MEM_ACCESS_TIMEOUT_EN is defined.
module tb_lc3_mem_access;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] M_addr = 16'h0000;
    logic [15:0] M_data = 16'h0000;
    logic [15:0] Data_dout;
    logic        complete_data = 1'b1;
    logic [15:0] Data_addr;
    logic [15:0] Data_din;
    logic        Data_rd;
    logic [15:0] memout;
    logic        busy;
    logic        done;
    logic        err;

    logic [15:0] mem [0:65535];
    logic        pokeEn = 1'b0;
    logic [15:0] pokeAddr = 16'h0000;
    logic [15:0] pokeData = 16'h0000;

    logic [15:0] addrHist [0:63];
    int vectors = 0;
    int miscompares = 0;
    int stallFrom = 0;
    int stallLen = 0;
    int busyStartAt = 0;
    int cyc;
    int wr;

    lc3_mem_access dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .mode          (mode),
        .M_addr        (M_addr),
        .M_data        (M_data),
        .Data_dout     (Data_dout),
        .complete_data (complete_data),
        .Data_addr     (Data_addr),
        .Data_din      (Data_din),
        .Data_rd       (Data_rd),
        .memout        (memout),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clock = ~clock;

    // Synchronous memory: writes whenever Data_rd is low, one-cycle read latency.
    always @(posedge clock) begin
        if (pokeEn) begin
            mem[pokeAddr] <= pokeData;
        end else if (!Data_rd) begin
            mem[Data_addr] <= Data_din;
        end
        Data_dout <= mem[Data_addr];
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        pokeEn   = 1'b1;
        pokeAddr = a;
        pokeData = d;
        step();
        pokeEn   = 1'b0;
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [15:0] a, input logic [15:0] d);
        start  = 1'b1;
        mode   = m;
        M_addr = a;
        M_data = d;
        step();
        start  = 1'b0;
    endtask

    // Launches one access and steps until done; cycles counts edges from the start edge.
    task automatic runAccess(input logic [1:0] m, input logic [15:0] a, input logic [15:0] d,
                             output int cycles, output int writes);
        applyStimulus(m, a, d);
        cycles = 1;
        addrHist[1] = Data_addr;
        writes = (Data_rd === 1'b0) ? 1 : 0;
        while (done !== 1'b1 && cycles < 60) begin
            complete_data = !(stallLen > 0 && cycles >= stallFrom && cycles < stallFrom + stallLen);
            if (busyStartAt != 0 && cycles == busyStartAt) begin
                start  = 1'b1;
                mode   = 2'b01;
                M_addr = 16'h3200;
                M_data = 16'hDEAD;
            end
            step();
            start = 1'b0;
            cycles++;
            if (cycles < 64) addrHist[cycles] = Data_addr;
            if (Data_rd === 1'b0) writes++;
        end
        complete_data = 1'b1;
        if (done !== 1'b1) checkOutput("done_wait_bound", {15'd0, done}, 16'h0001);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_addr"},   Data_addr, 16'h0000);
        checkOutput({tag, "_din"},    Data_din, 16'h0000);
        checkOutput({tag, "_rd"},     {15'd0, Data_rd}, 16'h0001);
        checkOutput({tag, "_memout"}, memout, 16'h0000);
        checkOutput({tag, "_busy"},   {15'd0, busy}, 16'h0000);
        checkOutput({tag, "_done"},   {15'd0, done}, 16'h0000);
        checkOutput({tag, "_err"},    {15'd0, err}, 16'h0000);
    endtask

    initial begin
        step();
        step();
        step();
        checkResetValues("reset");
        reset = 1'b1;
        step();

        poke(16'h3000, 16'h1234);
        poke(16'h3004, 16'h1111);
        poke(16'h3005, 16'h0000);
        poke(16'h3006, 16'h2222);
        poke(16'h3010, 16'h4000);
        poke(16'h4000, 16'h00A5);
        poke(16'h3020, 16'hFFFF);
        poke(16'hFFFF, 16'h0000);
        poke(16'h3100, 16'hCAFE);
        poke(16'h3200, 16'h0000);
        poke(16'h3300, 16'h0000);

        runAccess(2'b00, 16'h3000, 16'h0000, cyc, wr);
        checkOutput("ld_cycles", 16'(cyc), 16'd3);
        checkOutput("ld_memout", memout, 16'h1234);
        checkOutput("ld_writes", 16'(wr), 16'd0);
        checkOutput("ld_busy_at_done", {15'd0, busy}, 16'h0000);
        step();

        runAccess(2'b01, 16'h3005, 16'hBEEF, cyc, wr);
        checkOutput("st_cycles", 16'(cyc), 16'd2);
        checkOutput("st_writes", 16'(wr), 16'd1);
        checkOutput("st_mem3005", mem[16'h3005], 16'hBEEF);
        checkOutput("st_mem3004", mem[16'h3004], 16'h1111);
        checkOutput("st_mem3006", mem[16'h3006], 16'h2222);
        checkOutput("st_memout_kept", memout, 16'h1234);
        step();

        runAccess(2'b10, 16'h3010, 16'h0000, cyc, wr);
        checkOutput("ldi_cycles", 16'(cyc), 16'd5);
        checkOutput("ldi_ptr_addr", addrHist[1], 16'h3010);
        checkOutput("ldi_data_addr", addrHist[3], 16'h4000);
        checkOutput("ldi_memout", memout, 16'h00A5);
        checkOutput("ldi_writes", 16'(wr), 16'd0);
        step();

        runAccess(2'b11, 16'h3020, 16'h0007, cyc, wr);
        checkOutput("sti_cycles", 16'(cyc), 16'd4);
        checkOutput("sti_writes", 16'(wr), 16'd1);
        checkOutput("sti_wr_addr", addrHist[3], 16'hFFFF);
        checkOutput("sti_memFFFF", mem[16'hFFFF], 16'h0007);
        checkOutput("sti_memout_kept", memout, 16'h00A5);
        step();

        stallFrom   = 2;
        stallLen    = 3;
        busyStartAt = 2;
        runAccess(2'b00, 16'h3100, 16'h0000, cyc, wr);
        stallLen    = 0;
        busyStartAt = 0;
        checkOutput("stall_cycles", 16'(cyc), 16'd6);
        checkOutput("stall_memout", memout, 16'hCAFE);
        checkOutput("stall_writes", 16'(wr), 16'd0);
        checkOutput("busy_start_dropped", mem[16'h3200], 16'h0000);

        // Still in the done cycle: this start must be dropped.
        applyStimulus(2'b01, 16'h3300, 16'h5555);
        checkOutput("done_start_busy", {15'd0, busy}, 16'h0000);
        step();
        step();
        checkOutput("done_start_mem", mem[16'h3300], 16'h0000);

        runAccess(2'b00, 16'h3000, 16'h0000, cyc, wr);
        checkOutput("ld2_cycles", 16'(cyc), 16'd3);
        checkOutput("ld2_memout", memout, 16'h1234);
        step();

        applyStimulus(2'b10, 16'h3010, 16'h0000);
        step();
        step();
        checkOutput("mid_ldi_addr", Data_addr, 16'h4000);
        reset = 1'b0;
        step();
        checkResetValues("midreset");
        reset = 1'b1;
        step();

`ifdef MEM_ACCESS_TIMEOUT_EN
        stallFrom = 2;
        stallLen  = 100;
        runAccess(2'b00, 16'h3000, 16'h0000, cyc, wr);
        stallLen  = 0;
        checkOutput("tmo_cycles", 16'(cyc), 16'd18);
        checkOutput("tmo_err", {15'd0, err}, 16'h0001);
        checkOutput("tmo_memout_kept", memout, 16'h0000);
        checkOutput("tmo_rd", {15'd0, Data_rd}, 16'h0001);
        step();
        runAccess(2'b00, 16'h3000, 16'h0000, cyc, wr);
        checkOutput("tmo_err_cleared", {15'd0, err}, 16'h0000);
        checkOutput("tmo_next_memout", memout, 16'h1234);
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lc3_mem_access.md
# lc3_mem_access

LC3 memory-access stage controller: the initiator side of the data-memory port. On a one-cycle `start` it performs a load, store, indirect load (LDI) or indirect store (STI) against the synchronous data memory by driving `Data_addr`/`Data_din`/`Data_rd` and honouring `complete_data`. It then returns the loaded word on `memout` with a one-cycle `done`. It sits between the LC3 execute stage and the `Data_*` ports of the LC3 top level.

## Interface
- `TIMEOUT_CYCLES`, 16: wait-cycle limit; used only with `MEM_ACCESS_TIMEOUT_EN`.
- `clock`  in  1  sole clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-low (0 = reset).
- `start`  in  1  one-cycle request pulse; ignored while `busy`=1.
- `mode`  in  2  access type, sampled with `start`: 00 LD, 01 ST, 10 LDI, 11 STI.
- `M_addr`  in  16  effective address (pointer address for LDI/STI).
- `M_data`  in  16  store value for ST/STI.
- `Data_dout`  in  16  memory read data.
- `complete_data`  in  1  memory ready/acknowledge.
- `Data_addr`  out  16  memory address.
- `Data_din`  out  16  memory write data.
- `Data_rd`  out  1  1 = read, 0 = write. Memory writes on every edge where this is 0.
- `memout`  out  16  last loaded word.
- `busy`  out  1  request in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  timeout flag (sticky until next `start`).

## Operation
- Every output is registered.
- Reset values: `Data_addr`=0, `Data_din`=0, `Data_rd`=1, `memout`=0, `busy`=0, `done`=0, `err`=0, state IDLE.
- `Data_rd` is 1 in every state except WR. Idle and read states must never write memory.
- States and transitions:
  - IDLE: on `start` latch `mode`/`M_data`, set `Data_addr`=`M_addr`, set `busy`=1. Next state: LDI/STI → PRD; LD → RD; ST → WR.
  - PRD: pointer read issued; go to PCAP.
  - PCAP: if `complete_data`, set `Data_addr`=`Data_dout`. Go to RD for LDI, WR for STI. Otherwise hold.
  - RD: read issued; go to CAP.
  - CAP: if `complete_data`, set `memout`=`Data_dout` and go to DONE. Otherwise hold.
  - WR: `Data_rd`=0, `Data_din`=latched `M_data`. If `complete_data`, go to DONE with `Data_rd` returning to 1. Otherwise hold; rewriting the same word is harmless.
  - DONE: `done`=1, `busy`=0, go to IDLE.
- `memout` changes only in CAP. Stores leave it unchanged.
- A `start` in DONE or any busy state is dropped; no queueing.
- Reset low in any state forces reset values at the next edge and aborts any in-flight access.
- Address arithmetic: none. The pointer value from memory is used verbatim and wraps naturally within 16 bits.

## Timing
- `start` is sampled at edge E0; the address is visible after E0.
- Memory has one-cycle read latency: it captures at E1 and data is valid after E1.
- With `complete_data` held at 1:
  - LD: `done` high in cycle after E2 (3-cycle occupancy).
  - ST: `done` high after E1.
  - LDI: `done` high after E4.
  - STI: `done` high after E3.
- Each cycle `complete_data`=0 in PCAP, CAP or WR adds one cycle.
- Earliest back-to-back `start` is accepted in the cycle after `done`.

## Configuration
- `MEM_ACCESS_TIMEOUT_EN` defined:
  - A counter runs in PCAP, CAP and WR and clears on each state entry.
  - When it reaches `TIMEOUT_CYCLES` with `complete_data`=0: set `err`=1, force `Data_rd`=1, go to DONE, leave `memout` unchanged.
  - `err` clears on the next accepted `start`.
- Undefined: waits indefinitely; `err` is tied to 0 and no counter logic is present.

## Structure
- Mode encodings (LD/ST/LDI/STI) and state encodings go in shared `data_defs.v` as `` `define``s, alongside the existing LC3 definitions.
- One sub-module, `lc3_mem_timeout`: a cycle counter with `clear`, `enable` and `expired`. Instantiated only under the macro.

## Test plan
- LD: memory [3000]=0x1234; `start`, `mode`=00, `M_addr`=0x3000 → `memout`=0x1234 and `done` 3 cycles after start. `Data_rd` never 0.
- ST: `mode`=01, `M_addr`=0x3005, `M_data`=0xBEEF → exactly one cycle `Data_rd`=0, then [3005]=0xBEEF. Neighbouring words unchanged.
- LDI: [3010]=0x4000, [4000]=0x00A5 → `Data_addr` sequence 0x3010 then 0x4000, `memout`=0x00A5, `done` after 5 cycles.
- STI: [3020]=0xFFFF, `M_data`=0x0007 → write at 0xFFFF, [FFFF]=0x0007.
- LD with `complete_data` low for 3 cycles in CAP → `done` delayed by 3. A `start` during `busy` is ignored.
- Reset pulled low mid-LDI → all outputs at reset values the next cycle. With the macro and `complete_data` stuck at 0 for 16 cycles → `err`=1, `done` pulses.
